// File: rtl/uart_mmio_v2.sv
// Memory-mapped UART slave: programmable baud divisor, 16x-oversampled RX,
// RX/TX FIFOs, sticky W1C error flags, FIFO level readback, maskable irq.

// Circular-buffer byte FIFO; a push while full is taken only alongside a pop.
module uart_mmio_v2_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     push_ok
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign dout    = mem[rptr];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (push_ok && !do_pop)      count <= count + 1'b1;
            else if (!push_ok && do_pop) count <= count - 1'b1;
        end
    end
endmodule

module uart_mmio_v2 #(
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned DEFAULT_DIV = 53
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic        uart_rx,
    output logic        uart_tx
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_DATA, T_STOP} tx_state_t;

    logic [2:0]  sel;
    logic        rd, wr, wr_data, wr_status, wr_ctrl, wr_baud;
    logic [15:0] baud_div, baud_cnt;
    logic        tick16;
    logic [2:0]  ctrl;
    logic        rx_ovr, frame_err, tx_ovf;

    logic [1:0]  rx_sync;
    logic        rx_s;
    rx_state_t   rx_state;
    logic [3:0]  rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_done, rx_push, rx_pop, rx_push_ok, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;

    tx_state_t   tx_state;
    logic [3:0]  tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_pop, tx_push_ok, tx_full, tx_empty, tx_pending;
    logic [7:0]  tx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic        unused_bits;

    assign sel       = addr[4:2];
    assign rd        = en & ~we;
    assign wr        = en & we;
    assign wr_data   = wr & (sel == 3'd0);
    assign wr_status = wr & (sel == 3'd1);
    assign wr_ctrl   = wr & (sel == 3'd2);
    assign wr_baud   = wr & (sel == 3'd3);
    assign rx_pop    = rd & (sel == 3'd0);
    assign tick16    = (baud_cnt == '0);
    assign rx_s      = rx_sync[1];
    assign rx_done   = (rx_state == R_STOP) & tick16 & (rx_cnt == 4'd15);
    assign rx_push   = rx_done & rx_s;
    assign tx_pending = (tx_state != T_IDLE) | ~tx_empty;
    assign tx_pop    = ~tx_empty & ((tx_state == T_IDLE) |
                       ((tx_state == T_STOP) & tick16 & (tx_cnt == 4'd15)));
    assign unused_bits = ^{addr[31:5], addr[1:0], wdata[31:16]};

    uart_mmio_v2_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_sh), .pop(rx_pop),
        .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty),
        .push_ok(rx_push_ok)
    );

    uart_mmio_v2_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_data), .din(wdata[7:0]), .pop(tx_pop),
        .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty),
        .push_ok(tx_push_ok)
    );

    // Baud tick down-counter; period BAUD_DIV+1, reloaded on BAUD writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        baud_cnt <= DEFAULT_DIV[15:0];
        else if (wr_baud)  baud_cnt <= wdata[15:0];
        else if (tick16)   baud_cnt <= baud_div;
        else               baud_cnt <= baud_cnt - 1'b1;
    end

    // Control registers and sticky flags; a set beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= '0;
            baud_div  <= DEFAULT_DIV[15:0];
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl     <= wdata[2:0];
            if (wr_baud) baud_div <= wdata[15:0];
            rx_ovr    <= (rx_push & ~rx_push_ok) | (rx_ovr & ~(wr_status & wdata[4]));
            frame_err <= (rx_done & ~rx_s) | (frame_err & ~(wr_status & wdata[5]));
            tx_ovf    <= (wr_data & ~tx_push_ok) | (tx_ovf & ~(wr_status & wdata[6]));
            irq       <= (ctrl[0] & ~rx_empty) | (ctrl[1] & ~tx_pending) |
                         (ctrl[2] & (rx_ovr | frame_err | tx_ovf));
        end
    end

    // RX synchroniser and receive FSM (mid-bit sampling on tick16).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync  <= 2'b11;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            case (rx_state)
                R_IDLE: if (!rx_s) begin
                    rx_state <= R_START;
                    rx_cnt   <= '0;
                end
                R_START: if (tick16) begin
                    if (rx_cnt == 4'd7) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: if (tick16) begin
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_cnt == 4'd15) begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                    end
                end
                R_STOP: if (tick16) begin
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_cnt == 4'd15) rx_state <= R_IDLE;
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Transmit FSM; LOAD holds the popped byte until the next tick so every
    // bit spans exactly 16 ticks, and STOP chains directly into the next START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                T_IDLE: if (!tx_empty) begin
                    tx_sh    <= tx_head;
                    tx_state <= T_LOAD;
                end
                T_LOAD: if (tick16) begin
                    tx_state <= T_START;
                    tx_cnt   <= '0;
                    uart_tx  <= 1'b0;
                end
                T_START: if (tick16) begin
                    tx_cnt <= tx_cnt + 1'b1;
                    if (tx_cnt == 4'd15) begin
                        tx_state <= T_DATA;
                        tx_bit   <= '0;
                        uart_tx  <= tx_sh[0];
                    end
                end
                T_DATA: if (tick16) begin
                    tx_cnt <= tx_cnt + 1'b1;
                    if (tx_cnt == 4'd15) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= T_STOP;
                            uart_tx  <= 1'b1;
                        end else begin
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            uart_tx <= tx_sh[1];
                            tx_bit  <= tx_bit + 1'b1;
                        end
                    end
                end
                T_STOP: if (tick16) begin
                    tx_cnt <= tx_cnt + 1'b1;
                    if (tx_cnt == 4'd15) begin
                        if (!tx_empty) begin
                            tx_sh    <= tx_head;
                            tx_state <= T_START;
                            uart_tx  <= 1'b0;
                        end else begin
                            tx_state <= T_IDLE;
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Combinational read mux, zero outside read cycles.
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (sel)
                3'd0: rdata[7:0] = rx_empty ? 8'h00 : rx_head;
                3'd1: rdata[6:0] = {tx_ovf, frame_err, rx_ovr, rx_full, tx_full,
                                    tx_pending, ~rx_empty};
                3'd2: rdata[2:0] = ctrl;
                3'd3: rdata[15:0] = baud_div;
                3'd4: rdata[15:0] = {8'(tx_count), 8'(rx_count)};
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio_v2.sv
// Directed bench for uart_mmio_v2: registers, loopback, FIFO overflow,
// frame errors, glitch rejection, slow baud and mid-frame reset.
module tb_uart_mmio_v2;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam logic [31:0] A_DATA   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_CTRL   = 32'h08;
    localparam logic [31:0] A_BAUD   = 32'h0C;
    localparam logic [31:0] A_LEVEL  = 32'h10;
    localparam logic [31:0] A_RSV5   = 32'h14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        irq, uart_tx, uart_rx;
    logic        loop_en = 1'b0, rx_drv = 1'b1;
    int          checks = 0, errors = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    uart_mmio_v2 #(.RX_DEPTH(16), .TX_DEPTH(16), .DEFAULT_DIV(53)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .uart_rx(uart_rx), .uart_tx(uart_tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); en = 1'b1; we = 1'b1; addr = BASE + a; wdata = d;
        @(negedge clk); en = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); en = 1'b1; we = 1'b0; addr = BASE + a;
        #1 d = rdata;
        @(negedge clk); en = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_level(input logic [31:0] exp, input int budget);
        logic [31:0] d;
        int t = 0;
        rd(A_LEVEL, d);
        while (d !== exp && t < budget) begin
            rd(A_LEVEL, d);
            t++;
        end
        chk("level_wait", d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b,
                              input int bitlen, input int stoplen);
        @(negedge clk); rx_drv = 1'b0;
        repeat (bitlen - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rx_drv = b[i];
            repeat (bitlen - 1) @(negedge clk);
        end
        @(negedge clk); rx_drv = stop_b;
        repeat (stoplen - 1) @(negedge clk);
        @(negedge clk); rx_drv = 1'b1;
    endtask

    // Returns {start_ok, stop_ok, byte}; zero on timeout.
    task automatic tx_decode(output logic [31:0] res);
        logic [7:0] b;
        logic       s0, s1;
        int t = 0;
        res = '0;
        b = '0;
        while (uart_tx !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t < 2000) begin
            repeat (8) @(negedge clk);
            s0 = ~uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (16) @(negedge clk);
            s1 = uart_tx;
            res = {22'd0, s0, s1, b};
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  bv;

        // Reset values
        cycles(3);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        rd_chk("rst_status", A_STATUS, 32'h0);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_baud", A_BAUD, 32'd53);
        rd_chk("rst_level", A_LEVEL, 32'h0);
        rd_chk("empty_data", A_DATA, 32'h0);
        wr(A_RSV5, 32'hFFFF_FFFF);
        rd_chk("rsv5", A_RSV5, 32'h0);
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd_chk("ctrl_mask", A_CTRL, 32'h7);
        chk("irq_tx_idle", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_BAUD, 32'h0);
        rd_chk("baud0", A_BAUD, 32'h0);

        // 1: loopback
        loop_en = 1'b1;
        wr(A_DATA, 32'hA5);
        wr(A_DATA, 32'h3C);
        wait_level(32'h0000_0002, 800);
        rd_chk("lb_b0", A_DATA, 32'hA5);
        rd_chk("lb_b1", A_DATA, 32'h3C);
        rd(A_STATUS, d);
        chk("lb_rxne", d & 32'h1, 32'h0);
        cycles(30);
        loop_en = 1'b0;

        // 2: TX overflow and ordering (slow baud holds byte 0 in LOAD)
        wr(A_BAUD, 32'd199);
        for (int k = 0; k < 17; k++) wr(A_DATA, 32'(8'(k * 37 + 5)));
        rd_chk("txq_level", A_LEVEL, 32'h0000_1000);
        rd_chk("txq_status", A_STATUS, 32'h06);
        wr(A_DATA, 32'hEE);
        rd_chk("txovf_status", A_STATUS, 32'h46);
        rd_chk("txovf_level", A_LEVEL, 32'h0000_1000);
        wr(A_BAUD, 32'h0);
        for (int k = 0; k < 17; k++) begin
            tx_decode(d);
            bv = 8'(k * 37 + 5);
            chk($sformatf("tx_frame%0d", k), d, {22'd0, 2'b11, bv});
        end
        cycles(20);
        wr(A_STATUS, 32'h40);
        rd_chk("txovf_clr", A_STATUS, 32'h0);
        wr(A_CTRL, 32'h2);
        chk("irq_latency", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_tx_ie", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0);

        // 3: RX overrun
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(8'h40 + k * 3), 1'b1, 16, 16);
            cycles(16);
        end
        cycles(30);
        rd_chk("rxovr_level", A_LEVEL, 32'h0000_0010);
        rd_chk("rxovr_status", A_STATUS, 32'h19);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        chk("irq_rx_ie", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h10);
        rd_chk("rxovr_clr", A_STATUS, 32'h09);
        for (int k = 0; k < 16; k++)
            rd_chk($sformatf("rx_byte%0d", k), A_DATA, 32'(8'(8'h40 + k * 3)));
        rd_chk("rx_drained", A_STATUS, 32'h0);

        // 4: framing error and err_ie
        send_frame(8'h55, 1'b0, 16, 12);
        cycles(40);
        rd_chk("ferr_status", A_STATUS, 32'h20);
        rd_chk("ferr_level", A_LEVEL, 32'h0);
        wr(A_CTRL, 32'h4);
        chk("irq_err_lat", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_err", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'h20);
        chk("irq_err_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irq_err_clr", {31'd0, irq}, 32'd0);
        rd_chk("ferr_clr", A_STATUS, 32'h0);
        wr(A_CTRL, 32'h0);

        // 5: glitch reject, then slow baud
        @(negedge clk); rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(40);
        rd_chk("glitch_status", A_STATUS, 32'h0);
        rd_chk("glitch_level", A_LEVEL, 32'h0);
        wr(A_BAUD, 32'd53);
        send_frame(8'h0D, 1'b1, 864, 864);
        cycles(100);
        rd_chk("slow_level", A_LEVEL, 32'h1);
        rd_chk("slow_data", A_DATA, 32'h0D);

        // 6: reset mid TX frame
        wr(A_BAUD, 32'h0);
        wr(A_CTRL, 32'h7);
        wr(A_DATA, 32'h00);
        wr(A_DATA, 32'h11);
        wr(A_DATA, 32'h22);
        wr(A_DATA, 32'h33);
        cycles(40);
        chk("midframe_low", {31'd0, uart_tx}, 32'd0);
        rd_chk("midframe_level", A_LEVEL, 32'h0000_0300);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("rst_async_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        rd_chk("inrst_ctrl", A_CTRL, 32'h0);
        rd_chk("inrst_baud", A_BAUD, 32'd53);
        rd_chk("inrst_status", A_STATUS, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        cycles(50);
        rd_chk("post_level", A_LEVEL, 32'h0);
        rd_chk("post_status", A_STATUS, 32'h0);
        chk("post_tx", {31'd0, uart_tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
